// File: rtl/ctrl_tx_if.sv
// Control-link transmitter bus: frame request, seven control values, serial line and status.
interface ctrl_tx_if;
  logic       go;
  logic [7:0] a8, a5, a4, blend, delay, feedbk, gain;
  logic       TX;
  logic       busy;
  logic       done;

  modport master (output go, a8, a5, a4, blend, delay, feedbk, gain,
                  input  TX, busy, done);
  modport slave  (input  go, a8, a5, a4, blend, delay, feedbk, gain,
                  output TX, busy, done);
endinterface

// File: rtl/ctrl_tx.sv
// 8N1 frame transmitter for the analog-controls link: SYNC, seven snapshot values, checksum.
module ctrl_tx #(
  parameter int         fCLK = 50_000_000,
  parameter int         BAUD = 115_200,
  parameter logic [7:0] SYNC = 8'hA5,
  parameter int         BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  ctrl_tx_if.slave   bus
);
  localparam int DIV = fCLK / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d, bit_nx;
  logic [3:0]           byte_q, byte_d;
  logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                 load, bit_end;
  logic [8:0][BITS-1:0] frame_q;
  logic [BITS-1:0]      cur_byte, chk_d;

  assign chk_d    = bus.a8 + bus.a5 + bus.a4 + bus.blend + bus.delay + bus.feedbk + bus.gain;
  assign cur_byte = frame_q[byte_q];
  assign bit_end  = (baud_q == DIV_M1);
  assign bit_nx   = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.go) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = cur_byte[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_nx;
          tx_d  = cur_byte[bit_nx];
        end
      end
      STOP: if (bit_end) begin
        if (byte_q < 4'd8) begin
          state_d = START;
          byte_d  = byte_q + 4'd1;
          tx_d    = 1'b0;
        end else begin
          // Frame end; a go on this same edge restarts with no idle gap.
          done_d  = 1'b1;
          byte_d  = '0;
          bit_d   = '0;
          state_d = bus.go ? START : IDLE;
          tx_d    = ~bus.go;
          busy_d  = bus.go;
          load    = bus.go;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Snapshot register: index 0 goes out first.
  always_ff @(posedge clk) begin
    if (load)
      frame_q <= {chk_d, bus.gain, bus.feedbk, bus.delay, bus.blend, bus.a4, bus.a5, bus.a8, SYNC};
  end

  assign bus.TX   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_ctrl_tx.sv
// Randomized bench for ctrl_tx with a frame-level reference model and a bit-sampling decoder.
module tb_ctrl_tx;
  localparam int DIV   = 10;
  localparam int FRAME = 90 * DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_tx_if ifc();
  ctrl_tx #(.fCLK(1000), .BAUD(100), .SYNC(8'hA5), .BITS(8)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit armed = 0;

  // Reference model: frame position counter plus the nine bytes of the frame in flight
  bit         m_busy = 0, m_done = 0;
  int         m_cnt = 0;
  int         acc_cyc = 0, last_done_cyc = 0, dut_done = 0;
  logic [7:0] m_frame [9];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] rx_byte;

  function automatic logic exp_bit(int c);
    int bi, by, b;
    bi = c / DIV;
    by = bi / 10;
    b  = bi % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_frame[by][b-1];
  endfunction

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_queues(string name);
    check({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check(name, rx_q[i], exp_q[i]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        armed  = 1;
        m_busy = 0;
        m_done = 0;
        m_cnt  = 0;
      end else begin
        m_done = 0;
        if (m_busy) begin
          m_cnt++;
          if (m_cnt == FRAME) begin
            m_busy = 0;
            m_done = 1;
          end
        end
        if (!m_busy && ifc.go) begin
          m_frame[0] = 8'hA5;
          m_frame[1] = ifc.a8;   m_frame[2] = ifc.a5;    m_frame[3] = ifc.a4;
          m_frame[4] = ifc.blend; m_frame[5] = ifc.delay; m_frame[6] = ifc.feedbk;
          m_frame[7] = ifc.gain;
          m_frame[8] = 8'((ifc.a8 + ifc.a5 + ifc.a4 + ifc.blend + ifc.delay + ifc.feedbk + ifc.gain) % 256);
          for (int i = 0; i < 9; i++) exp_q.push_back(m_frame[i]);
          m_busy  = 1;
          m_cnt   = 0;
          acc_cyc = cyc;
        end
      end
      #1;
      if (armed) begin
        n_chk++;
        if ({ifc.TX, ifc.busy, ifc.done} !== {(m_busy ? exp_bit(m_cnt) : 1'b1), m_busy, m_done}) begin
          n_fail++;
          $display("FAIL line cyc=%0d: TX/busy/done got %b%b%b expected %b%b%b", cyc,
                   ifc.TX, ifc.busy, ifc.done, (m_busy ? exp_bit(m_cnt) : 1'b1), m_busy, m_done);
        end
        if (ifc.done === 1'b1) begin
          dut_done++;
          last_done_cyc = cyc;
        end
        // Mid-bit sampling of the DUT line rebuilds the bytes actually sent
        if (m_busy && (m_cnt % DIV) == DIV / 2) begin
          int b;
          b = (m_cnt / DIV) % 10;
          if (b >= 1 && b <= 8) rx_byte[b-1] = ifc.TX;
          if (b == 9) rx_q.push_back(rx_byte);
        end
      end
    end
  end

  task automatic set_vals(logic [7:0] v1, v2, v3, v4, v5, v6, v7);
    ifc.a8 = v1; ifc.a5 = v2; ifc.a4 = v3; ifc.blend = v4;
    ifc.delay = v5; ifc.feedbk = v6; ifc.gain = v7;
  endtask

  task automatic rand_vals();
    set_vals(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic pulse_go();
    @(negedge clk) ifc.go = 1'b1;
    @(negedge clk) ifc.go = 1'b0;
  endtask

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] lit_basic [9] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C};
  logic [7:0] lit_ff    [9] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9};

  initial begin
    int d0;
    reset = 1'b1;
    ifc.go = 1'b0;
    set_vals(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_tx", ifc.TX, 1);
    check("idle_busy", ifc.busy, 0);
    check("idle_done_count", dut_done, 0);

    // Basic frame against literal bytes
    clear_q();
    d0 = dut_done;
    set_vals(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    pulse_go();
    repeat (FRAME + 5) @(negedge clk);
    check("basic_len", rx_q.size(), 9);
    for (int i = 0; i < rx_q.size() && i < 9; i++) check("basic_byte", rx_q[i], lit_basic[i]);
    check("basic_done_latency", last_done_cyc - acc_cyc, 900);
    check("basic_done_count", dut_done - d0, 1);

    // Checksum wrap
    clear_q();
    set_vals(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pulse_go();
    repeat (FRAME + 5) @(negedge clk);
    check("wrap_len", rx_q.size(), 9);
    for (int i = 0; i < rx_q.size() && i < 9; i++) check("wrap_byte", rx_q[i], lit_ff[i]);

    // Snapshot holds and a go during busy is dropped
    clear_q();
    d0 = dut_done;
    rand_vals();
    ifc.gain = 8'h10;
    pulse_go();
    repeat (48) @(negedge clk);
    ifc.gain = 8'h20;
    ifc.go = 1'b1;
    @(negedge clk) ifc.go = 1'b0;
    repeat (FRAME) @(negedge clk);
    check("snap_len", rx_q.size(), 9);
    if (rx_q.size() == 9) check("snap_gain", rx_q[7], 8'h10);
    check("snap_done_count", dut_done - d0, 1);
    check("snap_busy_fall", last_done_cyc - acc_cyc, 900);
    check("snap_idle", ifc.busy, 0);

    // Back-to-back with fresh inputs every cycle
    clear_q();
    d0 = dut_done;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rand_vals();
      ifc.go = 1'b1;
    end
    @(negedge clk) ifc.go = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    check("b2b_done_count", dut_done - d0, 3);
    check_queues("b2b_byte");

    // Reset mid-frame, then a clean frame
    d0 = dut_done;
    rand_vals();
    pulse_go();
    repeat (436) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rst_tx", ifc.TX, 1);
    check("rst_busy", ifc.busy, 0);
    repeat (FRAME) @(negedge clk);
    check("rst_no_done", dut_done - d0, 0);
    clear_q();
    rand_vals();
    pulse_go();
    repeat (FRAME + 5) @(negedge clk);
    check("rst_done_count", dut_done - d0, 1);
    check_queues("rst_byte");

    // Random frames with random idle gaps
    clear_q();
    for (int k = 0; k < 4; k++) begin
      rand_vals();
      pulse_go();
      repeat (FRAME + $urandom_range(0, 30)) @(negedge clk);
    end
    repeat (FRAME) @(negedge clk);
    check_queues("rand_byte");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
